elastic_pipe_chain: RTL and testbench

- Parametrised replacement for the fixed Fetch/Decode, Decode/Execute, Execute/Memory and Memory/Writeback pipeline registers.
- Provides a chain of DEPTH registered stages, each WIDTH bits wide, with a per-stage valid bit.
- Uses a valid/ready handshake with bubble collapsing, a synchronous flush for branch/jump redirect, and an occupancy counter for the hazard/stall logic.
- Sits between any two pipeline units; one instance replaces a run of back-to-back stage registers.

---
 rtl/elastic_pipe_chain.sv | 85 ++++++++
 tb/tb_elastic_pipe_chain.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_chain.sv
// Elastic chain of DEPTH registered pipeline stages with bubble collapsing,
// a synchronous redirect flush and a registered occupancy count.
module elastic_pipe_chain #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] occupancy
);
    // Handshake: a word crosses a boundary on the edge where the sender's valid
    // and the receiver's ready are both 1; valid never waits on ready.
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_valid;
    logic [DEPTH-1:0] valid_next;
    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_next;

    // A stage may load when it is empty or when the stage ahead of it moves.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_ready | ~valid_q[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = adv[i+1] | ~valid_q[i];
        end
    end

    assign in_ready = adv[0] & ~flush;

    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid & in_ready;
        src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    always_comb begin
        valid_next = '0;
        occ_next   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_next[i] = flush ? 1'b0 : (adv[i] ? src_valid[i] : valid_q[i]);
            occ_next      = occ_next + CNT_W'(valid_next[i]);
        end
    end

    // Payload only moves with a valid word; flush leaves stage data untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_next;
            occ_q   <= occ_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (!flush && adv[i] && src_valid[i]) begin
                    data_q[i] <= src_data[i];
                end
            end
        end
    end

    assign out_valid   = valid_q[DEPTH-1];
    assign out_data    = data_q[DEPTH-1];
    assign stage_valid = valid_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Self-checking bench for elastic_pipe_chain: a word-level position model
// compared every cycle, plus directed vectors with literal expectations.
module tb_elastic_pipe_chain;
    localparam int D  = 4;
    localparam int W  = 16;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          flush;
    logic [D-1:0]  stage_valid;
    logic [CW-1:0] occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    elastic_pipe_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: each in-flight word is a (position, payload) pair, oldest first.
    // A word steps forward unless the word ahead of it ends up directly in front.
    logic [W-1:0] exp_q[$];
    int           pos_q[$];
    logic [W-1:0] last_out;
    logic [W-1:0] got_q[$];
    int           new_pos [D];
    int           lim;
    logic [D-1:0] m_sv;
    logic         m_in_ready;
    logic         m_out_valid;

    always @(negedge clk) begin
        #4;
        if (!reset) begin
            exp_q.delete();
            pos_q.delete();
            last_out = '0;
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            chk("rst_occupancy", 32'(occupancy), 32'(0));
            chk("rst_stage_valid", 32'(stage_valid), 32'(0));
            chk("rst_out_data", 32'(out_data), 32'(0));
        end else begin
            m_sv = '0;
            foreach (pos_q[k]) m_sv[pos_q[k]] = 1'b1;
            m_out_valid = (pos_q.size() > 0) && (pos_q[0] == D - 1);
            lim = out_ready ? D + 1 : D;
            for (int k = 0; k < pos_q.size(); k++) begin
                new_pos[k] = (pos_q[k] + 1 < lim) ? pos_q[k] + 1 : pos_q[k];
                lim = new_pos[k];
            end
            m_in_ready = !flush && (pos_q.size() == 0 || new_pos[pos_q.size() - 1] > 0);

            chk("out_valid", 32'(out_valid), 32'(m_out_valid));
            chk("out_data", 32'(out_data), 32'(last_out));
            chk("stage_valid", 32'(stage_valid), 32'(m_sv));
            chk("occupancy", 32'(occupancy), 32'(pos_q.size()));
            chk("in_ready", 32'(in_ready), 32'(m_in_ready));

            if (out_valid && out_ready) got_q.push_back(out_data);
            if (m_out_valid && out_ready) chk("sb_order", 32'(out_data), 32'(exp_q[0]));

            if (flush) begin
                exp_q.delete();
                pos_q.delete();
            end else begin
                for (int k = 0; k < pos_q.size(); k++) begin
                    if (new_pos[k] == D - 1 && pos_q[k] != D - 1) last_out = exp_q[k];
                    pos_q[k] = new_pos[k];
                end
                if (pos_q.size() > 0 && pos_q[0] == D) begin
                    void'(pos_q.pop_front());
                    void'(exp_q.pop_front());
                end
                if (in_valid && m_in_ready) begin
                    exp_q.push_back(in_data);
                    pos_q.push_back(0);
                    if (D == 1) last_out = in_data;
                end
            end
        end
    end

    // driver tasks
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #2;
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) cyc(1'b0, '0, r, 1'b0);
    endtask

    task automatic chk_got(input string name, input logic [W-1:0] first, input int n);
        chk({name, "_count"}, 32'(got_q.size()), 32'(n));
        for (int k = 0; k < n && k < got_q.size(); k++) begin
            chk(name, 32'(got_q[k]), 32'(first + W'(k)));
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("lit_rst_out_valid", 32'(out_valid), 32'(0));
        chk("lit_rst_occupancy", 32'(occupancy), 32'(0));
        chk("lit_rst_stage_valid", 32'(stage_valid), 32'(4'b0000));
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #2;
        chk("lit_in_ready_after_reset", 32'(in_ready), 32'(1));

        // streaming, one word per cycle
        got_q.delete();
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, W'(k), 1'b1, 1'b0);
            if (k == 5) begin
                chk("lit_stream_first_valid", 32'(out_valid), 32'(1));
                chk("lit_stream_first_data", 32'(out_data), 32'(16'h0001));
                chk("lit_stream_occ", 32'(occupancy), 32'(4));
            end
            if (k == 8) begin
                chk("lit_stream_occ_steady", 32'(occupancy), 32'(4));
                chk("lit_stream_data_steady", 32'(out_data), 32'(16'h0004));
            end
        end
        idle(8, 1'b1);
        chk_got("lit_stream_seq", 16'h0001, 8);

        // backpressure, collapse, then full push+pop
        got_q.delete();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 16'hA000 + W'(k), 1'b0, 1'b0);
            chk("lit_bp_accept", 32'(in_ready), 32'(1));
        end
        cyc(1'b1, 16'hA004, 1'b0, 1'b0);
        chk("lit_bp_full_ready", 32'(in_ready), 32'(0));
        chk("lit_bp_full_occ", 32'(occupancy), 32'(4));
        chk("lit_bp_full_sv", 32'(stage_valid), 32'(4'b1111));
        cyc(1'b1, 16'hA004, 1'b0, 1'b0);
        chk("lit_bp_hold_data", 32'(out_data), 32'(16'hA000));
        cyc(1'b1, 16'hA004, 1'b1, 1'b0);
        chk("lit_full_pushpop_ready", 32'(in_ready), 32'(1));
        cyc(1'b1, 16'hA005, 1'b1, 1'b0);
        chk("lit_full_pushpop_occ", 32'(occupancy), 32'(4));
        chk("lit_full_pushpop_data", 32'(out_data), 32'(16'hA001));
        idle(8, 1'b1);
        chk_got("lit_bp_seq", 16'hA000, 6);

        // flush with a concurrent input word
        got_q.delete();
        for (int k = 1; k <= 3; k++) cyc(1'b1, 16'hC000 + W'(k), 1'b0, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b1);
        chk("lit_flush_ready", 32'(in_ready), 32'(0));
        chk("lit_flush_occ_before", 32'(occupancy), 32'(3));
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("lit_flush_occ_after", 32'(occupancy), 32'(0));
        chk("lit_flush_out_valid", 32'(out_valid), 32'(0));
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b0);
        chk("lit_flush_represent", 32'(in_ready), 32'(1));
        idle(6, 1'b1);
        chk_got("lit_flush_seq", 16'hBEEF, 1);

        // flush while the output word is consumed, then flush when empty
        got_q.delete();
        for (int k = 1; k <= 4; k++) cyc(1'b1, 16'hF000 + W'(k), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("lit_flush_out_data", 32'(out_data), 32'(16'hF001));
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("lit_flush_empty_occ", 32'(occupancy), 32'(0));
        chk("lit_flush_empty_ready", 32'(in_ready), 32'(1));
        chk_got("lit_flush_consumed", 16'hF001, 1);

        // asynchronous reset mid-stream
        got_q.delete();
        for (int k = 1; k <= 3; k++) cyc(1'b1, 16'hD000 + W'(k), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("lit_arst_occ_before", 32'(occupancy), 32'(3));
        reset = 1'b0;
        #1;
        chk("lit_arst_out_valid", 32'(out_valid), 32'(0));
        chk("lit_arst_occ", 32'(occupancy), 32'(0));
        chk("lit_arst_sv", 32'(stage_valid), 32'(0));
        chk("lit_arst_out_data", 32'(out_data), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("lit_arst_release_ready", 32'(in_ready), 32'(1));
        cyc(1'b1, 16'hE001, 1'b1, 1'b0);
        idle(6, 1'b1);
        chk_got("lit_arst_seq", 16'hE001, 1);

        // mixed traffic checked by the model alone
        for (int k = 0; k < 80; k++) begin
            cyc(1'($urandom_range(0, 1)), W'($urandom_range(0, 16'hFFFF)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        idle(8, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
